fifo_rd_streamer: RTL and testbench

Read-side drain engine for the 128-bit synchronous FIFO. It issues read strobes into the FIFO's read port and absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer. Popped words are re-presented on a valid/ready stream to the downstream consumer. It sits between the FIFO read port and any consumer that needs back-pressure, and sustains one word per cycle.

---
 rtl/fifo_rd_streamer_if.sv | 22 ++
 rtl/fifo_rd_streamer.sv | 84 ++++++++
 tb/tb_fifo_rd_streamer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus downstream valid/ready stream handled by fifo_rd_streamer.
`timescale 1ns/1ps
interface fifo_rd_streamer_if #(
  parameter int unsigned DATA_W = 128
);
  logic              i_empty;
  logic [DATA_W-1:0] i_rddata;
  logic              o_rden;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;

  modport master (
    input  i_empty, i_rddata, i_ready,
    output o_rden, o_valid, o_data
  );

  modport slave (
    output i_empty, i_rddata, i_ready,
    input  o_rden, o_valid, o_data
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side drain engine: read strobes, 2-entry skid buffer, valid/ready output.
// Optional handshake counter enabled by defining FIFO_RD_STATS_EN.
`timescale 1ns/1ps
module fifo_rd_streamer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_flush,
  fifo_rd_streamer_if.master  bus,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_rd_count
);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic [1:0]        cnt;
  logic              inflight;
  logic              valid;
  logic              pop;
  logic              rden;
  logic [1:0]        cnt_after_pop;
  logic [2:0]        occ;

  assign valid = (cnt != 2'd0);

  // Occupancy after this edge counts the in-flight word, so the buffer never overflows.
  always_comb begin
    pop           = valid & bus.i_ready;
    cnt_after_pop = cnt - {1'b0, pop};
    occ           = {1'b0, cnt_after_pop} + {2'b00, inflight};
    rden          = !rst & i_en & !i_flush & !bus.i_empty & (occ < 3'd2);
  end

  assign bus.o_rden  = rden;
  assign bus.o_valid = valid;
  assign bus.o_data  = e0;
  assign o_busy      = valid | inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      inflight <= 1'b0;
      e0       <= '0;
      e1       <= '0;
    end else if (i_flush) begin
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rden;
      cnt      <= cnt_after_pop + {1'b0, inflight};
      if (pop) begin
        e0 <= e1;
      end
      // Capture lands in the first free slot after the pop; overrides the shift into e0.
      if (inflight) begin
        if (cnt_after_pop == 2'd0) begin
          e0 <= bus.i_rddata;
        end else begin
          e1 <= bus.i_rddata;
        end
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] rd_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNT_W'(1);
    end
  end

  assign o_rd_count = rd_count;
`else
  assign o_rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural 1-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_fifo_rd_streamer;

  localparam int unsigned TB_DATA_W = 128;
  localparam int unsigned TB_CNT_W  = 4;

  logic clk;
  logic rst;
  logic i_en;
  logic i_flush;
  logic o_busy;
  logic [TB_CNT_W-1:0] o_rd_count;

  fifo_rd_streamer_if #(.DATA_W(TB_DATA_W)) bus ();

  fifo_rd_streamer #(
    .DATA_W(TB_DATA_W),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_flush   (i_flush),
    .bus       (bus),
    .o_busy    (o_busy),
    .o_rd_count(o_rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data appears on i_rddata the cycle after a strobe, garbage otherwise.
  logic [TB_DATA_W-1:0] mem [0:2047];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign bus.i_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.o_rden) begin
      bus.i_rddata <= mem[rd_ptr[10:0]];
      rd_ptr       <= rd_ptr + 1;
    end else begin
      bus.i_rddata <= {4{32'hDEADBEEF}};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    mem[wr_ptr[10:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic exp_cyc(input string t, input int c, input bit r, input bit v,
                         input bit b, input logic [127:0] d);
    chk($sformatf("%s_rden_c%0d", t, c), bus.o_rden, r);
    chk($sformatf("%s_valid_c%0d", t, c), bus.o_valid, v);
    chk($sformatf("%s_busy_c%0d", t, c), o_busy, b);
    if (v) chk($sformatf("%s_data_c%0d", t, c), bus.o_data, d);
  endtask

  function automatic logic [127:0] exp_cnt(input int unsigned n);
`ifdef FIFO_RD_STATS_EN
    return 128'(n % (1 << TB_CNT_W));
`else
    return '0;
`endif
  endfunction

  function automatic logic [127:0] word(input int unsigned i);
    return {32'(i), 32'hA5A50000 + 32'(i), ~32'(i), 32'(i) * 32'd3};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned pushed;

    rst         = 1'b1;
    i_en        = 1'b1;
    i_flush     = 1'b0;
    bus.i_ready = 1'b0;
    for (int unsigned w = 1; w <= 4; w++) push(128'(w));

    // Reset state with a non-empty FIFO and enable high
    step_cyc();
    step_cyc();
    sample();
    chk("rst_rden", bus.o_rden, 1'b0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_data", bus.o_data, 128'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_count", o_rd_count, 128'd0);

    // Streaming 0x1..0x4 with ready high
    for (int c = 0; c <= 6; c++) begin
      step_cyc();
      if (c == 0) begin
        rst         = 1'b0;
        bus.i_ready = 1'b1;
      end
      sample();
      exp_cyc("t1", c, c < 4, c >= 2 && c <= 5, c >= 1 && c <= 5, 128'(c - 1));
    end
    chk("t1_count", o_rd_count, exp_cnt(4));

    // Back-pressure: two reads, head held, then drain without gap
    for (int c = 0; c <= 10; c++) begin
      step_cyc();
      if (c == 0) for (int unsigned w = 'h11; w <= 'h14; w++) push(128'(w));
      bus.i_ready = (c >= 6);
      sample();
      exp_cyc("t2", c, c < 2 || c == 6 || c == 7, c >= 2 && c <= 9, c >= 1 && c <= 9,
              (c <= 6) ? 128'h11 : 128'(32'h11 + c - 6));
    end
    chk("t2_count", o_rd_count, exp_cnt(8));

    // Flush with cnt=2, then flush with cnt=1 and a word in flight
    for (int c = 0; c <= 11; c++) begin
      step_cyc();
      if (c == 0) for (int unsigned w = 'h21; w <= 'h26; w++) push(128'(w));
      i_flush     = (c == 3 || c == 6);
      bus.i_ready = (c >= 9);
      sample();
      exp_cyc("t3", c,
              c == 0 || c == 1 || c == 4 || c == 5 || c == 7 || c == 8,
              c == 2 || c == 3 || c == 6 || c == 9 || c == 10,
              c == 1 || c == 2 || c == 3 || c == 5 || c == 6 || c == 8 || c == 9 || c == 10,
              (c <= 3) ? 128'h21 : (c == 6) ? 128'h23 : (c == 9) ? 128'h25 : 128'h26);
    end
    i_flush = 1'b0;
    chk("t3_count", o_rd_count, exp_cnt(10));

    // Asynchronous reset mid-stream
    bus.i_ready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      step_cyc();
      if (c == 0) for (int unsigned w = 'h31; w <= 'h36; w++) push(128'(w));
      sample();
      exp_cyc("t4a", c, 1'b1, c >= 2, c >= 1, 128'(32'h31 + c - 2));
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t4_arst_rden", bus.o_rden, 1'b0);
    chk("t4_arst_valid", bus.o_valid, 1'b0);
    chk("t4_arst_busy", o_busy, 1'b0);
    chk("t4_arst_data", bus.o_data, 128'd0);
    chk("t4_arst_count", o_rd_count, 128'd0);
    for (int c = 0; c <= 5; c++) begin
      step_cyc();
      if (c == 0) rst = 1'b0;
      sample();
      exp_cyc("t4b", c, c <= 2, c >= 2 && c <= 4, c >= 1 && c <= 4, 128'(32'h34 + c - 2));
    end
    chk("t4_count", o_rd_count, exp_cnt(3));

    // Enable low stops new reads while the in-flight word still drains
    for (int c = 0; c <= 9; c++) begin
      step_cyc();
      if (c == 0) begin
        push(128'h41);
        push(128'h42);
      end
      i_en = (c == 2 || c >= 6);
      sample();
      exp_cyc("t6", c, c == 2 || c == 6, c == 4 || c == 8,
              c == 3 || c == 4 || c == 7 || c == 8, (c == 4) ? 128'h41 : 128'h42);
    end
    chk("t6_count", o_rd_count, exp_cnt(5));

    // Random ready and random FIFO fill over 1000 words
    k      = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 6000 && k < 1000; cyc++) begin
      step_cyc();
      bus.i_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push(word(pushed));
        pushed++;
      end
      sample();
      chk("rnd_no_rd_empty", bus.o_rden && bus.i_empty, 1'b0);
      chk("rnd_no_pop_cap_full",
          (dut.cnt == 2'd2) && dut.inflight && bus.o_valid && bus.i_ready, 1'b0);
      if (bus.o_valid && bus.i_ready) begin
        chk($sformatf("rnd_order_%0d", k), bus.o_data, word(k));
        k++;
      end
    end
    chk("rnd_word_total", 128'(k), 128'd1000);

    bus.i_ready = 1'b1;
    for (int c = 0; c < 3; c++) step_cyc();
    sample();
    chk("end_valid", bus.o_valid, 1'b0);
    chk("end_busy", o_busy, 1'b0);
    chk("end_rden", bus.o_rden, 1'b0);
    chk("end_count", o_rd_count, exp_cnt(1005));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
